// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: debounced exec button, RUN/IDLE/HALTED control, phase stepping and retire count.
// Optional single-instruction STEP mode and step_mode port are enabled by defining PHASE_STEP_EN.
module phase_sequencer #(
  parameter int unsigned NUM_PHASES      = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exec_raw,
  input  logic               halt_req,
`ifdef PHASE_STEP_EN
  input  logic               step_mode,
`endif
  output logic [2:0]         phase,
  output logic               running,
  output logic               halt,
  output logic               phase_wrap,
  output logic [COUNT_W-1:0] instr_count
);

  // A threshold of one accepted edge gives the edge-only behaviour for DEBOUNCE_CYCLES = 0
  localparam int unsigned   DB_TH   = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
  localparam int unsigned   DB_W    = $clog2(DB_TH + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_TH - 1);
  localparam logic [2:0]    LAST_PH = 3'(NUM_PHASES - 1);

`ifdef PHASE_STEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED, S_STEP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
`endif

  logic               r_sync1, r_sync2;
  logic               r_armed;
  logic               r_exec_pulse;
  logic [DB_W-1:0]    r_db_cnt;
  logic               w_db_match;

  state_t             r_state, w_state_nx;
  logic [2:0]         r_phase, w_phase_nx;
  logic               r_running, r_halt, r_wrap, w_wrap_nx;
  logic [COUNT_W-1:0] r_count, w_count_nx;
  logic               w_last, w_stop, w_running_nx, w_halt_nx;

  // Armed: counting consecutive high levels; disarmed: counting consecutive low levels
  assign w_db_match = r_armed ? r_sync2 : ~r_sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_armed      <= 1'b1;
      r_exec_pulse <= 1'b0;
      r_db_cnt     <= '0;
    end else begin
      r_sync1      <= exec_raw;
      r_sync2      <= r_sync1;
      r_exec_pulse <= 1'b0;
      if (!w_db_match) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt     <= '0;
        r_armed      <= ~r_armed;
        r_exec_pulse <= r_armed;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_last = (r_phase == LAST_PH);
  assign w_stop = (r_state == S_RUN) && r_exec_pulse;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_wrap_nx  = 1'b0;
    w_count_nx = r_count;
    case (r_state)
      S_IDLE: begin
        if (r_exec_pulse) begin
`ifdef PHASE_STEP_EN
          w_state_nx = step_mode ? S_STEP : S_RUN;
`else
          w_state_nx = S_RUN;
`endif
        end
      end
      S_HALTED: begin
        w_phase_nx = '0;
        if (r_exec_pulse) w_state_nx = S_RUN;
      end
      default: begin
        // RUN and STEP share the advance; exec stops RUN only, STEP ends after one wrap
        if (w_last) begin
          w_phase_nx = '0;
          w_wrap_nx  = 1'b1;
          w_count_nx = r_count + COUNT_W'(1);
          if (w_stop)                 w_state_nx = S_IDLE;
          else if (halt_req)          w_state_nx = S_HALTED;
          else if (r_state != S_RUN)  w_state_nx = S_IDLE;
        end else if (w_stop) begin
          w_state_nx = S_IDLE;
        end else begin
          w_phase_nx = r_phase + 3'd1;
        end
      end
    endcase
`ifdef PHASE_STEP_EN
    w_running_nx = (w_state_nx == S_RUN) || (w_state_nx == S_STEP);
`else
    w_running_nx = (w_state_nx == S_RUN);
`endif
    w_halt_nx = (w_state_nx == S_HALTED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_running <= 1'b0;
      r_halt    <= 1'b0;
      r_wrap    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_phase   <= w_phase_nx;
      r_running <= w_running_nx;
      r_halt    <= w_halt_nx;
      r_wrap    <= w_wrap_nx;
      r_count   <= w_count_nx;
    end
  end

  assign phase       = r_phase;
  assign running     = r_running;
  assign halt        = r_halt;
  assign phase_wrap  = r_wrap;
  assign instr_count = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus randomized exec/halt traffic
// compared against a cycle-level behavioural model.
module tb_phase_sequencer;

  localparam int unsigned NP = 5;
  localparam int unsigned DB = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned TH = (DB == 0) ? 1 : DB;
`ifdef PHASE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          exec_raw;
  logic          halt_req;
  logic          step_mode;
  logic [2:0]    phase;
  logic          running;
  logic          halt;
  logic          phase_wrap;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  phase_sequencer #(
    .NUM_PHASES(NP),
    .DEBOUNCE_CYCLES(DB),
    .COUNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .exec_raw(exec_raw),
    .halt_req(halt_req),
`ifdef PHASE_STEP_EN
    .step_mode(step_mode),
`endif
    .phase(phase),
    .running(running),
    .halt(halt),
    .phase_wrap(phase_wrap),
    .instr_count(instr_count)
  );

  // Model: mode 0 idle, 1 run, 2 halted, 3 step
  int m_mode;
  int m_phase;
  bit m_wrap;
  int m_count;
  bit m_s1, m_s2, m_armed, m_pulse;
  bit q_hist[$];

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_wrap = 0; m_count = 0;
    m_s1 = 0; m_s2 = 0; m_armed = 1; m_pulse = 0;
    q_hist.delete();
  endtask

  task automatic model_step();
    bit pulse_in;
    bit lvl;
    bit stop;
    int ones;
    pulse_in = m_pulse;
    lvl      = m_s2;
    m_wrap   = 0;
    case (m_mode)
      0: if (pulse_in) m_mode = (STEP_EN && step_mode) ? 3 : 1;
      2: begin
        m_phase = 0;
        if (pulse_in) m_mode = 1;
      end
      default: begin
        stop = (m_mode == 1) && pulse_in;
        if (m_phase == NP - 1) begin
          m_phase = 0;
          m_wrap  = 1;
          m_count = (m_count + 1) % (1 << CW);
          if (stop)          m_mode = 0;
          else if (halt_req) m_mode = 2;
          else if (m_mode == 3) m_mode = 0;
        end else if (stop) begin
          m_mode = 0;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    endcase
    // Exec acceptance: the last TH synchronized levels must all agree
    m_pulse = 0;
    q_hist.push_back(lvl);
    if (q_hist.size() > TH) void'(q_hist.pop_front());
    if (q_hist.size() == TH) begin
      ones = 0;
      foreach (q_hist[i]) ones += int'(q_hist[i]);
      if (m_armed && ones == int'(TH)) begin
        m_pulse = 1;
        m_armed = 0;
      end else if (!m_armed && ones == 0) begin
        m_armed = 1;
      end
    end
    m_s2 = m_s1;
    m_s1 = exec_raw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("phase",       32'(phase),       32'(m_phase));
    chk("running",     32'(running),     32'((m_mode == 1) || (m_mode == 3)));
    chk("halt",        32'(halt),        32'(m_mode == 2));
    chk("phase_wrap",  32'(phase_wrap),  32'(m_wrap));
    chk("instr_count", 32'(instr_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    int saved;
    reset = 1'b1; exec_raw = 1'b0; halt_req = 1'b0; step_mode = 1'b0;
    apply_reset();

    // Short glitch must not be accepted
    exec_raw = 1'b1;
    repeat (3) tick();
    exec_raw = 1'b0;
    repeat (10) tick();
    chk("glitch_running", 32'(running), 32'd0);
    chk("glitch_phase",   32'(phase),   32'd0);

    // Held press: running on edge 7, then one full instruction
    apply_reset();
    exec_raw = 1'b1;
    repeat (6) tick();
    chk("edge6_running", 32'(running), 32'd0);
    tick();
    chk("edge7_running", 32'(running), 32'd1);
    chk("edge7_phase",   32'(phase),   32'd0);
    repeat (4) tick();
    chk("ph4_phase", 32'(phase), 32'd4);
    tick();
    chk("wrap_pulse", 32'(phase_wrap),  32'd1);
    chk("wrap_phase", 32'(phase),       32'd0);
    chk("wrap_count", 32'(instr_count), 32'd1);
    tick();
    chk("wrap_once", 32'(phase_wrap), 32'd0);

    // Pause with phase frozen at 2, then resume at 3
    exec_raw = 1'b0;
    repeat (TH + 4) tick();
    for (int k = 0; k < 10 && m_phase != 1; k++) tick();
    chk("sync_phase1", 32'(phase), 32'd1);
    exec_raw = 1'b1;
    repeat (7) tick();
    chk("pause_running", 32'(running), 32'd0);
    chk("pause_phase",   32'(phase),   32'd2);
    repeat (5) tick();
    chk("pause_hold", 32'(phase), 32'd2);
    exec_raw = 1'b0;
    repeat (TH + 4) tick();
    exec_raw = 1'b1;
    repeat (7) tick();
    chk("resume_running", 32'(running), 32'd1);
    chk("resume_phase",   32'(phase),   32'd2);
    tick();
    chk("resume_next", 32'(phase), 32'd3);

    // halt_req at phase 3 ignored, at phase 4 halts
    for (int k = 0; k < 10 && m_phase != 3; k++) tick();
    halt_req = 1'b1;
    tick();
    chk("h3_halt",  32'(halt),  32'd0);
    chk("h3_phase", 32'(phase), 32'd4);
    saved = int'(instr_count);
    tick();
    halt_req = 1'b0;
    chk("h4_halt",    32'(halt),        32'd1);
    chk("h4_running", 32'(running),     32'd0);
    chk("h4_phase",   32'(phase),       32'd0);
    chk("h4_count",   32'(instr_count), 32'(saved + 1));
    repeat (4) tick();
    exec_raw = 1'b0;
    repeat (TH + 4) tick();
    exec_raw = 1'b1;
    repeat (7) tick();
    chk("unhalt_running", 32'(running), 32'd1);
    chk("unhalt_halt",    32'(halt),    32'd0);
    chk("unhalt_phase",   32'(phase),   32'd0);

    // Randomized traffic against the model
    hold = 0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        exec_raw = 1'($urandom_range(0, 1));
        hold     = int'($urandom_range(1, 12));
      end
      hold--;
      halt_req  = ($urandom_range(0, 3) == 0);
      step_mode = 1'($urandom_range(0, 1));
      tick();
    end
    halt_req = 1'b0; step_mode = 1'b0;

    // Asynchronous reset mid-instruction
    apply_reset();
    exec_raw = 1'b1;
    for (int k = 0; k < 200 && !(m_count == 9 && m_phase == 3); k++) tick();
    chk("pre_rst_count", 32'(instr_count), 32'd9);
    chk("pre_rst_phase", 32'(phase),       32'd3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst_phase",   32'(phase),       32'd0);
    chk("arst_running", 32'(running),     32'd0);
    chk("arst_halt",    32'(halt),        32'd0);
    chk("arst_wrap",    32'(phase_wrap),  32'd0);
    chk("arst_count",   32'(instr_count), 32'd0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    exec_raw = 1'b0;
    repeat (3) tick();

`ifdef PHASE_STEP_EN
    // Single-instruction step
    apply_reset();
    step_mode = 1'b1;
    exec_raw  = 1'b1;
    repeat (7) tick();
    chk("step_running", 32'(running), 32'd1);
    chk("step_phase0",  32'(phase),   32'd0);
    repeat (4) tick();
    chk("step_phase4", 32'(phase), 32'd4);
    tick();
    chk("step_wrap",    32'(phase_wrap),  32'd1);
    chk("step_count",   32'(instr_count), 32'd1);
    chk("step_idle",    32'(running),     32'd0);
    chk("step_phase_0", 32'(phase),       32'd0);
    repeat (10) tick();
    chk("step_stays", 32'(running), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
